// File: rtl/fifo_monitor.sv
// Black-box checker for a first-word-fall-through FIFO interface, built around a shadow FIFO.
// Define FIFO_MON_COVER_EN to build the coverage counters; otherwise the cov_* outputs are tied to 0.
module fifo_monitor #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 8,
  localparam int unsigned OCC_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mon_wr_en,
  input  logic [DATA_WIDTH-1:0] mon_wr_data,
  input  logic                  mon_rd_en,
  input  logic [DATA_WIDTH-1:0] mon_rd_data,
  input  logic                  mon_full,
  input  logic                  mon_empty,
  input  logic                  err_clr,
  output logic [6:0]            err_flags,
  output logic [CNT_W-1:0]      err_count,
  output logic                  first_err_vld,
  output logic [2:0]            first_err_code,
  output logic [DATA_WIDTH-1:0] mm_exp,
  output logic [DATA_WIDTH-1:0] mm_got,
  output logic [OCC_W-1:0]      occupancy,
  output logic [15:0]           cov_push,
  output logic [15:0]           cov_pop,
  output logic [15:0]           cov_both,
  output logic [15:0]           cov_full,
  output logic [15:0]           cov_empty
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] OccFull = OCC_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PtrLast = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
  logic [OCC_W-1:0]      occ_q;

  logic                  push_ok, pop_ok, occ_zero, occ_full, do_push, do_pop;
  logic [DATA_WIDTH-1:0] head;
  logic [6:0]            v;
  logic [2:0]            low_idx;

  logic [6:0]            flags_base, err_flags_d;
  logic [CNT_W-1:0]      count_base, err_count_d;
  logic                  vld_base, first_err_vld_d;
  logic [2:0]            code_base, first_err_code_d;
  logic [DATA_WIDTH-1:0] exp_base, got_base, mm_exp_d, mm_got_d;

  always_comb begin
    push_ok  = mon_wr_en & ~mon_full;
    pop_ok   = mon_rd_en & ~mon_empty;
    occ_zero = (occ_q == '0);
    occ_full = (occ_q == OccFull);
    head     = mem_q[rd_ptr_q];
    do_pop   = pop_ok & ~occ_zero;
    do_push  = push_ok & (~occ_full | do_pop);

    v[0] = mon_wr_en & mon_full;
    v[1] = mon_rd_en & mon_empty;
    v[2] = mon_full & mon_empty;
    v[3] = mon_empty != occ_zero;
    v[4] = mon_full != occ_full;
    v[5] = do_pop & (mon_rd_data != head);
    v[6] = push_ok & ~pop_ok & occ_full;
  end

  always_comb begin
    low_idx = '0;
    for (int i = 6; i >= 0; i--) begin
      if (v[i]) low_idx = 3'(i);
    end
  end

  // Clear is applied first so a violation in the clearing cycle still lands.
  always_comb begin
    flags_base = err_clr ? '0 : err_flags;
    count_base = err_clr ? '0 : err_count;
    vld_base   = err_clr ? 1'b0 : first_err_vld;
    code_base  = err_clr ? '0 : first_err_code;
    exp_base   = err_clr ? '0 : mm_exp;
    got_base   = err_clr ? '0 : mm_got;

    err_flags_d      = flags_base | v;
    err_count_d      = count_base;
    first_err_vld_d  = vld_base;
    first_err_code_d = code_base;
    mm_exp_d         = exp_base;
    mm_got_d         = got_base;

    if (|v && count_base != CntMax) err_count_d = count_base + 1'b1;
    if (|v && !vld_base) begin
      first_err_vld_d  = 1'b1;
      first_err_code_d = low_idx;
    end
    // Sticky bit 5 doubles as "mismatch already captured".
    if (v[5] && !flags_base[5]) begin
      mm_exp_d = head;
      mm_got_d = mon_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem_q[wr_ptr_q] <= mon_wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      occ_q          <= '0;
      err_flags      <= '0;
      err_count      <= '0;
      first_err_vld  <= 1'b0;
      first_err_code <= '0;
      mm_exp         <= '0;
      mm_got         <= '0;
    end else begin
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
      if (do_push) wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
      if (do_push && !do_pop)      occ_q <= occ_q + 1'b1;
      else if (do_pop && !do_push) occ_q <= occ_q - 1'b1;
      err_flags      <= err_flags_d;
      err_count      <= err_count_d;
      first_err_vld  <= first_err_vld_d;
      first_err_code <= first_err_code_d;
      mm_exp         <= mm_exp_d;
      mm_got         <= mm_got_d;
    end
  end

  assign occupancy = occ_q;

`ifdef FIFO_MON_COVER_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cov_push  <= '0;
      cov_pop   <= '0;
      cov_both  <= '0;
      cov_full  <= '0;
      cov_empty <= '0;
    end else begin
      cov_push  <= cov_push + {15'd0, push_ok & ~&cov_push};
      cov_pop   <= cov_pop + {15'd0, pop_ok & ~&cov_pop};
      cov_both  <= cov_both + {15'd0, push_ok & pop_ok & ~&cov_both};
      cov_full  <= cov_full + {15'd0, mon_full & ~&cov_full};
      cov_empty <= cov_empty + {15'd0, mon_empty & ~&cov_empty};
    end
  end
`else
  assign cov_push  = '0;
  assign cov_pop   = '0;
  assign cov_both  = '0;
  assign cov_full  = '0;
  assign cov_empty = '0;
`endif

endmodule

// File: tb/tb_fifo_monitor.sv
// Directed bench for fifo_monitor: queue-based reference model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_fifo_monitor;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mon_wr_en = 1'b0, mon_rd_en = 1'b0, mon_full = 1'b0, mon_empty = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] mon_wr_data = '0, mon_rd_data = '0;
  logic [6:0] err_flags;
  logic [7:0] err_count;
  logic       first_err_vld;
  logic [2:0] first_err_code;
  logic [7:0] mm_exp, mm_got;
  logic [2:0] occupancy;
  logic [15:0] cov_push, cov_pop, cov_both, cov_full, cov_empty;

  fifo_monitor #(.DATA_WIDTH(8), .FIFO_DEPTH(D), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .mon_wr_en(mon_wr_en), .mon_wr_data(mon_wr_data),
    .mon_rd_en(mon_rd_en), .mon_rd_data(mon_rd_data),
    .mon_full(mon_full), .mon_empty(mon_empty), .err_clr(err_clr),
    .err_flags(err_flags), .err_count(err_count),
    .first_err_vld(first_err_vld), .first_err_code(first_err_code),
    .mm_exp(mm_exp), .mm_got(mm_got), .occupancy(occupancy),
    .cov_push(cov_push), .cov_pop(cov_pop), .cov_both(cov_both),
    .cov_full(cov_full), .cov_empty(cov_empty)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a queue plus plain error bookkeeping.
  logic [7:0] q[$];
  logic [6:0] e_flags = '0;
  int         e_count = 0;
  bit         e_vld = 1'b0;
  int         e_code = 0;
  logic [7:0] e_exp = '0, e_got = '0;
  int         c_push = 0, c_pop = 0, c_both = 0, c_full = 0, c_empty = 0;
  int         m_occ;
  bit         m_pu, m_po;
  logic [6:0] m_v;
  logic [7:0] m_head;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      e_flags = '0; e_count = 0; e_vld = 1'b0; e_code = 0; e_exp = '0; e_got = '0;
      c_push = 0; c_pop = 0; c_both = 0; c_full = 0; c_empty = 0;
    end else begin
      m_occ  = q.size();
      m_pu   = mon_wr_en && !mon_full;
      m_po   = mon_rd_en && !mon_empty;
      m_head = (m_occ != 0) ? q[0] : 8'h00;
      m_v[0] = mon_wr_en && mon_full;
      m_v[1] = mon_rd_en && mon_empty;
      m_v[2] = mon_full && mon_empty;
      m_v[3] = mon_empty != (m_occ == 0);
      m_v[4] = mon_full != (m_occ == D);
      m_v[5] = m_po && m_occ != 0 && mon_rd_data != m_head;
      m_v[6] = m_pu && !m_po && m_occ == D;
      if (err_clr) begin
        e_flags = '0; e_count = 0; e_vld = 1'b0; e_code = 0; e_exp = '0; e_got = '0;
      end
      if (m_v != 0) begin
        if (e_count < 255) e_count++;
        if (!e_vld) begin
          e_vld = 1'b1;
          for (int i = 0; i < 7; i++) begin
            if (m_v[i]) begin
              e_code = i;
              break;
            end
          end
        end
      end
      if (m_v[5] && !e_flags[5]) begin
        e_exp = m_head;
        e_got = mon_rd_data;
      end
      e_flags = e_flags | m_v;
`ifdef FIFO_MON_COVER_EN
      if (m_pu) c_push++;
      if (m_po) c_pop++;
      if (m_pu && m_po) c_both++;
      if (mon_full) c_full++;
      if (mon_empty) c_empty++;
`endif
      if (m_po && m_occ != 0) void'(q.pop_front());
      if (m_pu && (m_occ < D || (m_po && m_occ != 0))) q.push_back(mon_wr_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("err_flags", 32'(err_flags), 32'(e_flags));
      chk("err_count", 32'(err_count), 32'(e_count));
      chk("first_err_vld", 32'(first_err_vld), 32'(e_vld));
      chk("first_err_code", 32'(first_err_code), 32'(e_code));
      chk("mm_exp", 32'(mm_exp), 32'(e_exp));
      chk("mm_got", 32'(mm_got), 32'(e_got));
      chk("occupancy", 32'(occupancy), 32'(q.size()));
      chk("cov_push", 32'(cov_push), 32'(c_push));
      chk("cov_pop", 32'(cov_pop), 32'(c_pop));
      chk("cov_both", 32'(cov_both), 32'(c_both));
      chk("cov_full", 32'(cov_full), 32'(c_full));
      chk("cov_empty", 32'(cov_empty), 32'(c_empty));
    end
  end

  task automatic drive(input bit rn, input bit wr, input logic [7:0] wd, input bit rd,
                       input logic [7:0] rdd, input bit fu, input bit em, input bit clr);
    rst_n = rn; mon_wr_en = wr; mon_wr_data = wd; mon_rd_en = rd;
    mon_rd_data = rdd; mon_full = fu; mon_empty = em; err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  // A well-behaved FIFO: flags and head follow the reference queue.
  task automatic good(input bit wr, input logic [7:0] wd, input bit rd, input bit clr);
    bit fu, em;
    fu = (q.size() == D);
    em = (q.size() == 0);
    drive(1'b1, wr, wd, rd, em ? 8'h00 : q[0], fu, em, clr);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_flags"}, 32'(err_flags), 0);
    chk({tag, "_count"}, 32'(err_count), 0);
    chk({tag, "_vld"}, 32'(first_err_vld), 0);
    chk({tag, "_mm"}, 32'({mm_exp, mm_got}), 0);
    chk({tag, "_occ"}, 32'(occupancy), 0);
    chk({tag, "_cov"}, 32'(cov_push | cov_pop | cov_both | cov_full | cov_empty), 0);
  endtask

  initial begin
    drive(1'b0, 0, 8'h00, 0, 8'h00, 0, 1, 0);
    drive(1'b0, 0, 8'h00, 0, 8'h00, 0, 1, 0);
    chk_en = 1'b1;
    all_zero("reset");

    // Fill and drain with a correct FIFO.
    good(1, 8'h11, 0, 0);
    good(1, 8'h22, 0, 0);
    good(1, 8'h33, 0, 0);
    good(1, 8'h44, 0, 0);
    chk("fill_occ", 32'(occupancy), 4);
    for (int i = 0; i < 4; i++) good(0, 8'h00, 1, 0);
    chk("drain_occ", 32'(occupancy), 0);
    chk("drain_flags", 32'(err_flags), 0);
    chk("drain_count", 32'(err_count), 0);

    // Simultaneous push and pop at occupancy 2.
    good(1, 8'h01, 0, 0);
    good(1, 8'h02, 0, 0);
    good(1, 8'h03, 1, 0);
    chk("both_occ", 32'(occupancy), 2);
    chk("both_flags", 32'(err_flags), 0);
`ifdef FIFO_MON_COVER_EN
    chk("both_cov", 32'(cov_both), 1);
`endif
    good(0, 8'h00, 1, 0);
    good(0, 8'h00, 1, 0);

    // Wrong head data on a pop.
    good(1, 8'hA5, 0, 0);
    drive(1'b1, 0, 8'h00, 1, 8'h5A, 0, 0, 0);
    chk("dmm_flags", 32'(err_flags), 32'h20);
    chk("dmm_code", 32'(first_err_code), 5);
    chk("dmm_exp", 32'(mm_exp), 32'hA5);
    chk("dmm_got", 32'(mm_got), 32'h5A);
    chk("dmm_count", 32'(err_count), 1);
    good(0, 8'h00, 0, 1);
    chk("clr_count", 32'(err_count), 0);

    // Empty flag asserted while the shadow holds 3 entries.
    good(1, 8'h10, 0, 0);
    good(1, 8'h20, 0, 0);
    good(1, 8'h30, 0, 0);
    for (int i = 0; i < 3; i++) drive(1'b1, 0, 8'h00, 0, 8'h00, 0, 1, 0);
    chk("emm_flags", 32'(err_flags), 32'h08);
    chk("emm_count", 32'(err_count), 3);
    drive(1'b1, 0, 8'h00, 0, 8'h00, 0, 1, 1);
    chk("emm_clr_count", 32'(err_count), 1);
    chk("emm_clr_code", 32'(first_err_code), 3);
    good(0, 8'h00, 0, 1);

    // Write into a FIFO claiming full and empty at once.
    good(1, 8'h40, 0, 0);
    drive(1'b1, 1, 8'h99, 0, 8'h00, 1, 1, 0);
    chk("fe_flags", 32'(err_flags), 32'h0D);
    chk("fe_code", 32'(first_err_code), 0);
    chk("fe_occ", 32'(occupancy), 4);
    good(0, 8'h00, 0, 1);

    // Shadow overflow held long enough to saturate the counter.
    for (int i = 0; i < 260; i++) drive(1'b1, 1, 8'h77, 0, 8'h00, 0, 0, 0);
    chk("ovf_flags", 32'(err_flags), 32'h50);
    chk("ovf_code", 32'(first_err_code), 4);
    chk("ovf_count", 32'(err_count), 255);
    chk("ovf_occ", 32'(occupancy), 4);
    good(0, 8'h00, 0, 1);

    // Reset mid-stream, then clean traffic.
    good(0, 8'h00, 1, 0);
    chk("pre_rst_occ", 32'(occupancy), 3);
    drive(1'b0, 1, 8'hEE, 0, 8'h00, 0, 0, 0);
    all_zero("midrst");
    good(1, 8'hC1, 0, 0);
    good(1, 8'hC2, 0, 0);
    good(0, 8'h00, 1, 0);
    good(0, 8'h00, 1, 0);
    chk("post_flags", 32'(err_flags), 0);
    chk("post_count", 32'(err_count), 0);
    chk("post_occ", 32'(occupancy), 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
